pipe_flow_ctrl: RTL and testbench

Control side of the pipeline register. Drives the per-stage we/clr inputs of an N-stage chain of pipeline registers with clr/we. Tracks a valid bit per stage and exposes valid/ready handshakes at the pipeline entry and exit. Collapses bubbles, stalls on downstream back-pressure and flushes on request. Sits beside the pipelined adder datapath and owns no data.

---
 rtl/pipe_flow_pkg.sv | 12 +
 rtl/pipe_flow_ctrl_vld_cell.sv | 40 ++++
 rtl/pipe_flow_ctrl.sv | 112 +++++++++++
 tb/tb_pipe_flow_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_flow_pkg.sv
// Shared constants and sizing helper for the pipeline flow controller.
// Default stage count, statistic counter width and occupancy width function.
package pipe_flow_pkg;

   localparam int DEF_STAGES  = 4;
   localparam int STALL_CNT_W = 16;

   function automatic int occ_width(input int stages);
      return $clog2(stages + 1);
   endfunction

endpackage

// File: rtl/pipe_flow_ctrl_vld_cell.sv
// One stage's valid bit: 1-cycle state, combinational we/clr to its data register.
// Advances when empty or when the stage ahead advances; reset/flush force we=clr=1.
module pipe_vld_cell (
   input  logic clk,
   input  logic reset,
   input  logic src,
   input  logic en_next,
   input  logic flush,
   output logic v,
   output logic en,
   output logic clr
);

   logic v_q;
   logic v_d;
   logic kill;

   always_comb begin
      kill = reset | flush;
      en   = kill | !v_q | en_next;
      clr  = kill | (en & !src);
      v_d  = v_q;
      if (kill) begin
         v_d = 1'b0;
      end else if (en) begin
         v_d = src;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v_q <= 1'b0;
      end else begin
         v_q <= v_d;
      end
   end

   assign v = v_q;

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Valid/ready control for an N-stage register chain: STAGES-cycle latency, 1 item/cycle.
// Stalls only when every stage is full and out_rdy=0; optional stall statistic under PIPE_FLOW_CTRL_STAT_EN.
module pipe_flow_ctrl
   import pipe_flow_pkg::*;
#(
   parameter int STAGES = DEF_STAGES,
   parameter int CW     = occ_width(STAGES)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_vld,
   output logic                   in_rdy,
   output logic                   out_vld,
   input  logic                   out_rdy,
   input  logic                   flush,
   output logic [STAGES-1:0]      stage_we,
   output logic [STAGES-1:0]      stage_clr,
   output logic [STAGES-1:0]      stage_vld,
   output logic [CW-1:0]          occupancy,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   logic [STAGES-1:0] v;
   logic [STAGES-1:0] en;
   logic [STAGES-1:0] en_next;
   logic [STAGES-1:0] src;
   logic              in_fire;
   logic              out_fire;
   logic [CW-1:0]     occ_q;
   logic [CW-1:0]     occ_d;

   assign in_rdy = en[0] & !flush & !reset;

   // en_next is the closed form of the ripple: stage i+1 advances unless it and
   // everything beyond it is full with the exit blocked.
   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      if (i == STAGES - 1) begin : g_last
         assign en_next[i] = out_rdy;
      end else begin : g_mid
         assign en_next[i] = out_rdy | ~&v[STAGES-1:i+1];
      end

      if (i == 0) begin : g_entry
         assign src[i] = in_vld & in_rdy;
      end else begin : g_chain
         assign src[i] = v[i-1];
      end

      pipe_vld_cell u_cell (
         .clk     (clk),
         .reset   (reset),
         .src     (src[i]),
         .en_next (en_next[i]),
         .flush   (flush),
         .v       (v[i]),
         .en      (en[i]),
         .clr     (stage_clr[i])
      );
   end

   assign stage_we  = en;
   assign stage_vld = v;
   assign out_vld   = v[STAGES-1];

   // An item leaving during a flush is dropped, so it is never counted out.
   assign in_fire  = in_vld & in_rdy;
   assign out_fire = out_vld & out_rdy & !flush;

   always_comb begin
      occ_d = occ_q;
      if (flush) begin
         occ_d = '0;
      end else begin
         occ_d = occ_q + CW'(in_fire) - CW'(out_fire);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occupancy = occ_q;

`ifdef PIPE_FLOW_CTRL_STAT_EN
   logic [STALL_CNT_W-1:0] stall_q;
   logic [STALL_CNT_W-1:0] stall_d;

   always_comb begin
      stall_d = stall_q;
      if (out_vld && !out_rdy && !flush && (stall_q != '1)) begin
         stall_d = stall_q + STALL_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Randomised and directed bench for pipe_flow_ctrl against an item-slot reference model.
module tb_pipe_flow_ctrl;
   import pipe_flow_pkg::*;

   localparam int S  = 4;
   localparam int CW = $clog2(S + 1);
`ifdef PIPE_FLOW_CTRL_STAT_EN
   localparam bit STAT = 1'b1;
`else
   localparam bit STAT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, in_vld, out_rdy, flush;
   logic          in_rdy, out_vld;
   logic [S-1:0]  stage_we, stage_clr, stage_vld;
   logic [CW-1:0] occupancy;
   logic [15:0]   stall_cnt;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   pipe_flow_ctrl #(.STAGES(S)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_vld    (in_vld),
      .in_rdy    (in_rdy),
      .out_vld   (out_vld),
      .out_rdy   (out_rdy),
      .flush     (flush),
      .stage_we  (stage_we),
      .stage_clr (stage_clr),
      .stage_vld (stage_vld),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt)
   );

   // Reference model: each slot holds an item id (-1 = empty), stage 0 = entry.
   int            slot [S];
   int            next_id = 0;
   int            e_stall = 0;
   logic          e_rdy, e_ovld;
   logic [S-1:0]  e_we, e_clr, e_vld;
   logic [CW-1:0] e_occ;
   logic [15:0]   e_stall_cnt;

   function automatic void model_eval();
      bit can;
      bit srcv;
      int cnt;
      cnt = 0;
      for (int i = 0; i < S; i++) begin
         e_vld[i] = (slot[i] >= 0);
         if (slot[i] >= 0) cnt++;
      end
      e_occ  = CW'(cnt);
      e_ovld = e_vld[S-1];
      if (reset || flush) begin
         e_we  = '1;
         e_clr = '1;
         e_rdy = 1'b0;
      end else begin
         can = out_rdy;
         for (int i = S - 1; i >= 0; i--) begin
            can     = !e_vld[i] || can;
            e_we[i] = can;
         end
         e_rdy = e_we[0];
         for (int i = 0; i < S; i++) begin
            srcv     = (i == 0) ? (in_vld && e_rdy) : e_vld[i-1];
            e_clr[i] = e_we[i] && !srcv;
         end
      end
      e_stall_cnt = STAT ? 16'(e_stall) : 16'd0;
   endfunction

   function automatic void model_commit();
      if (reset) begin
         for (int i = 0; i < S; i++) slot[i] = -1;
         e_stall = 0;
      end else if (flush) begin
         for (int i = 0; i < S; i++) slot[i] = -1;
      end else begin
         if (e_ovld && !out_rdy && e_stall < 65535) e_stall++;
         for (int i = S - 1; i >= 0; i--) begin
            if (e_we[i]) begin
               if (i > 0) slot[i] = slot[i-1];
               else if (in_vld && e_rdy) slot[i] = next_id++;
               else slot[i] = -1;
            end
         end
      end
   endfunction

   task automatic settle();
      model_eval();
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         n_cmp++;
         if (occupancy !== CW'($countones(stage_vld))) begin
            n_err++;
            $display("FAIL occ_invariant t=%0t got %0d want %0d", $time, occupancy, $countones(stage_vld));
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1; in_vld = 1'b1; out_rdy = 1'b0; flush = 1'b0;
      repeat (2) begin
         settle();
         n_cmp++; if (stage_we !== 4'hF) begin n_err++; $display("FAIL reset_we got %h want f", stage_we); end
         n_cmp++; if (stage_clr !== 4'hF) begin n_err++; $display("FAIL reset_clr got %h want f", stage_clr); end
         n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL reset_in_rdy got %b want 0", in_rdy); end
         adv();
      end
      reset = 1'b0; in_vld = 1'b0;
      settle();
      n_cmp++; if (stage_vld !== 4'h0) begin n_err++; $display("FAIL post_reset_vld got %h want 0", stage_vld); end
      n_cmp++; if (occupancy !== '0) begin n_err++; $display("FAIL post_reset_occ got %0d want 0", occupancy); end
      n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL post_reset_out_vld got %b want 0", out_vld); end
      n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL post_reset_stall got %0d want 0", stall_cnt); end
      adv();
      chk_en = 1'b1;
   endtask

   task automatic test_stream();
      int first_out;
      first_out = -1;
      in_vld = 1'b1; out_rdy = 1'b1;
      for (int k = 0; k < 10; k++) begin
         settle();
         if (out_vld === 1'b1 && first_out < 0) first_out = k;
         n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL stream_in_rdy k=%0d got %b want 1", k, in_rdy); end
         if (k >= S) begin
            n_cmp++; if (occupancy !== CW'(S)) begin n_err++; $display("FAIL stream_occ k=%0d got %0d want %0d", k, occupancy, S); end
            n_cmp++; if (stage_clr !== 4'h0) begin n_err++; $display("FAIL stream_clr k=%0d got %h want 0", k, stage_clr); end
            n_cmp++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL stream_out_vld k=%0d got %b want 1", k, out_vld); end
         end
         adv();
      end
      n_cmp++; if (first_out != S) begin n_err++; $display("FAIL stream_latency got %0d want %0d", first_out, S); end
      in_vld = 1'b0;
      repeat (S + 1) begin settle(); adv(); end
   endtask

   task automatic test_backpressure();
      bit pat [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      out_rdy = 1'b0;
      for (int k = 0; k < 10; k++) begin
         in_vld = (k < 6) ? pat[k] : 1'b0;
         settle();
         adv();
      end
      in_vld = 1'b1;
      settle();
      n_cmp++; if (occupancy !== CW'(S)) begin n_err++; $display("FAIL bp_occ got %0d want %0d", occupancy, S); end
      n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL bp_in_rdy got %b want 0", in_rdy); end
      n_cmp++; if (stage_vld !== 4'hF) begin n_err++; $display("FAIL bp_vld got %h want f", stage_vld); end
      n_cmp++; if (stage_we !== 4'h0) begin n_err++; $display("FAIL bp_we got %h want 0", stage_we); end
      adv();
      in_vld = 1'b0; out_rdy = 1'b1;
      for (int k = 0; k < 6; k++) begin
         settle();
         n_cmp++; if (out_vld !== (k < 4)) begin n_err++; $display("FAIL bp_drain k=%0d got %b want %b", k, out_vld, (k < 4)); end
         adv();
      end
   endtask

   task automatic test_flush();
      bit pat [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      out_rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_vld = pat[k];
         settle();
         adv();
      end
      flush = 1'b1; out_rdy = 1'b1; in_vld = 1'b1;
      settle();
      n_cmp++; if (occupancy !== CW'(3)) begin n_err++; $display("FAIL flush_pre_occ got %0d want 3", occupancy); end
      n_cmp++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL flush_out_vld got %b want 1", out_vld); end
      n_cmp++; if (stage_clr !== 4'hF) begin n_err++; $display("FAIL flush_clr got %h want f", stage_clr); end
      n_cmp++; if (stage_we !== 4'hF) begin n_err++; $display("FAIL flush_we got %h want f", stage_we); end
      n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL flush_in_rdy got %b want 0", in_rdy); end
      adv();
      flush = 1'b0; out_rdy = 1'b0; in_vld = 1'b0;
      settle();
      n_cmp++; if (stage_vld !== 4'h0) begin n_err++; $display("FAIL flush_post_vld got %h want 0", stage_vld); end
      n_cmp++; if (occupancy !== '0) begin n_err++; $display("FAIL flush_post_occ got %0d want 0", occupancy); end
      adv();
   endtask

   task automatic test_back_to_back();
      in_vld = 1'b1; out_rdy = 1'b1;
      repeat (S) begin settle(); adv(); end
      for (int k = 0; k < 2; k++) begin
         settle();
         n_cmp++; if (stage_vld !== 4'hF) begin n_err++; $display("FAIL b2b_vld k=%0d got %h want f", k, stage_vld); end
         n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_in_rdy k=%0d got %b want 1", k, in_rdy); end
         n_cmp++; if (stage_we !== 4'hF) begin n_err++; $display("FAIL b2b_we k=%0d got %h want f", k, stage_we); end
         n_cmp++; if (occupancy !== CW'(S)) begin n_err++; $display("FAIL b2b_occ k=%0d got %0d want %0d", k, occupancy, S); end
         adv();
      end
      in_vld = 1'b0;
      repeat (S + 1) begin settle(); adv(); end
   endtask

   task automatic test_stall_cnt();
      logic [15:0] want;
      want = STAT ? 16'd5 : 16'd0;
      reset = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; flush = 1'b0;
      settle(); adv();
      reset = 1'b0; in_vld = 1'b1;
      repeat (S) begin settle(); adv(); end
      in_vld = 1'b0;
      settle();
      n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL stall_start got %0d want 0", stall_cnt); end
      n_cmp++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL stall_out_vld got %b want 1", out_vld); end
      adv();
      repeat (4) begin settle(); adv(); end
      flush = 1'b1;
      settle();
      n_cmp++; if (stall_cnt !== want) begin n_err++; $display("FAIL stall_five got %0d want %0d", stall_cnt, want); end
      adv();
      flush = 1'b0;
      settle();
      n_cmp++; if (stall_cnt !== want) begin n_err++; $display("FAIL stall_after_flush got %0d want %0d", stall_cnt, want); end
      adv();
   endtask

   task automatic test_random();
      for (int k = 0; k < 500; k++) begin
         reset   = ($urandom_range(0, 99) == 0);
         flush   = ($urandom_range(0, 29) == 0);
         in_vld  = ($urandom_range(0, 2) != 0);
         out_rdy = (k < 250) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         settle();
         n_cmp++; if (stage_we !== e_we) begin n_err++; $display("FAIL rnd_we k=%0d got %h want %h", k, stage_we, e_we); end
         n_cmp++; if (stage_clr !== e_clr) begin n_err++; $display("FAIL rnd_clr k=%0d got %h want %h", k, stage_clr, e_clr); end
         n_cmp++; if (in_rdy !== e_rdy) begin n_err++; $display("FAIL rnd_in_rdy k=%0d got %b want %b", k, in_rdy, e_rdy); end
         n_cmp++; if (out_vld !== e_ovld) begin n_err++; $display("FAIL rnd_out_vld k=%0d got %b want %b", k, out_vld, e_ovld); end
         n_cmp++; if (stage_vld !== e_vld) begin n_err++; $display("FAIL rnd_vld k=%0d got %h want %h", k, stage_vld, e_vld); end
         n_cmp++; if (occupancy !== e_occ) begin n_err++; $display("FAIL rnd_occ k=%0d got %0d want %0d", k, occupancy, e_occ); end
         n_cmp++; if (stall_cnt !== e_stall_cnt) begin n_err++; $display("FAIL rnd_stall k=%0d got %0d want %0d", k, stall_cnt, e_stall_cnt); end
         adv();
      end
      reset = 1'b0; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < S; i++) slot[i] = -1;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_back_to_back();
      test_stall_cnt();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t got running want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
